// File: rtl/bus_ctrl_if.sv
// bus_ctrl_if -- CPU-side and SRAM-side bus signals for bus_ctrl.
//   CPU side : mem_valid, mem_addr, mem_wdata, mem_wstrb -> controller
//              mem_ready, mem_rdata                      <- controller
//   SRAM side: sram_sel, sram_addr, sram_wstrb, sram_wdata <- controller
//              sram_ready, sram_rdata                      -> controller
//   modport slave : the controller's view (slave to the CPU, master to the SRAM)
//   modport master: the environment's view (CPU + SRAM)
interface bus_ctrl_if #(
    parameter int ADDRWIDTH = 13
);
    logic                 mem_valid;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic [3:0]           mem_wstrb;
    logic                 mem_ready;
    logic [31:0]          mem_rdata;

    logic                 sram_sel;
    logic [ADDRWIDTH-1:0] sram_addr;
    logic [3:0]           sram_wstrb;
    logic [31:0]          sram_wdata;
    logic                 sram_ready;
    logic [31:0]          sram_rdata;

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb, sram_ready, sram_rdata,
        output mem_ready, mem_rdata, sram_sel, sram_addr, sram_wstrb, sram_wdata
    );

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb, sram_ready, sram_rdata,
        input  mem_ready, mem_rdata, sram_sel, sram_addr, sram_wstrb, sram_wdata
    );
endinterface

// File: rtl/bus_ctrl.sv
// bus_ctrl -- single-outstanding CPU bus controller decoding to SRAM, a small
// IO block (GPIO register + free-running cycle counter) or an error response.
//   clk      : sole clock, rising edge
//   resetn   : asynchronous active-low reset
//   bus      : bus_ctrl_if.slave (CPU request/response + SRAM request/response)
//   gpio_out : 8-bit GPIO register
//   bus_err  : sticky error flag (bad address or SRAM timeout), cleared by reset
module bus_ctrl #(
    parameter int ADDRWIDTH = 13,
    parameter int TIMEOUT   = 15
) (
    input  logic           clk,
    input  logic           resetn,
    bus_ctrl_if.slave      bus,
    output logic [7:0]     gpio_out,
    output logic           bus_err
);
    localparam int WW = $clog2(TIMEOUT + 1);
    // Last wait-counter value still inside the window; hitting it without
    // sram_ready means TIMEOUT cycles of sram_sel have elapsed.
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SRAM_WAIT,
        IO,
        RESP,
        ERR
    } state_e;

    state_e               state_q, state_d;
    logic [ADDRWIDTH-1:0] addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [WW-1:0]        wait_q, wait_d;
    logic [7:0]           gpio_q, gpio_d;
    logic                 err_q, err_d;
    logic [31:0]          cyc_q;

    logic is_sram, is_io;
    assign is_sram = (bus.mem_addr[31:ADDRWIDTH] == '0);
    assign is_io   = (bus.mem_addr[31:28] == 4'h1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        wait_d  = wait_q;
        gpio_d  = gpio_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.mem_valid) begin
                    // Request is latched here; mem_valid is ignored afterwards.
                    addr_d  = bus.mem_addr[ADDRWIDTH-1:0];
                    wdata_d = bus.mem_wdata;
                    wstrb_d = bus.mem_wstrb;
                    wait_d  = '0;
                    if (is_sram)    state_d = SRAM_WAIT;
                    else if (is_io) state_d = IO;
                    else            state_d = ERR;
                end
            end
            SRAM_WAIT: begin
                if (bus.sram_ready) begin
                    rdata_d = (wstrb_q == 4'h0) ? bus.sram_rdata : 32'h0;
                    state_d = RESP;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ERR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            IO: begin
                rdata_d = 32'h0;
                if (wstrb_q == 4'h0) begin
                    case (addr_q[3:2])
                        2'd0:    rdata_d = {24'h0, gpio_q};
                        2'd1:    rdata_d = cyc_q;
                        default: rdata_d = 32'h0;
                    endcase
                end else if (addr_q[3:2] == 2'd0 && wstrb_q[0]) begin
                    gpio_d = wdata_q[7:0];
                end
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Set on entry so the flag is already visible alongside the error response.
        if (state_d == ERR) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            wait_q  <= '0;
            gpio_q  <= '0;
            err_q   <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            wait_q  <= wait_d;
            gpio_q  <= gpio_d;
            err_q   <= err_d;
            cyc_q   <= cyc_q + 32'd1;
        end
    end

    // Outputs decode straight from state, so an async reset drops them at once.
    assign bus.mem_ready  = (state_q == RESP) || (state_q == ERR);
    assign bus.mem_rdata  = (state_q == RESP) ? rdata_q :
                            (state_q == ERR)  ? 32'hDEAD_BEEF : 32'h0;
    assign bus.sram_sel   = (state_q == SRAM_WAIT);
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wstrb = wstrb_q;
    assign bus.sram_wdata = wdata_q;
    assign gpio_out       = gpio_q;
    assign bus_err        = err_q;
endmodule
